sht_meas_sched: RTL
===================

SHT_MEAS_SCHED -- requirements
Module: sht_meas_sched

Interface
REQ-001 Parameter PERIOD_CYC, default 12_000_000; clocks between measurement starts (1 s at 12 MHz).
REQ-002 Parameter MEAS_WAIT_CYC, default 180_000; clocks between trigger acknowledge and read (15 ms).
REQ-003 Parameter CONV_LAT, default 3; clocks of conversion-datapath latency.
REQ-004 Parameter RETRY_MAX, default 3; I2C/CRC retries per measurement.
REQ-005 clk  in  1  single system clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  periodic measurement enable.
REQ-008 i2c_req  out  1  transaction request to the I2C master, held until i2c_done.
REQ-009 i2c_cmd  out  1  0 = trigger measurement, 1 = read 6 bytes.
REQ-010 i2c_done  in  1  one-cycle transaction-complete pulse.
REQ-011 i2c_err  in  1  NACK flag, valid with i2c_done.
REQ-012 i2c_rdata  in  48  {T[15:0], CRC_T[7:0], H[15:0], CRC_H[7:0]}, valid with i2c_done.
REQ-013 raw_tem  out  16  raw temperature to the conversion datapath input.
REQ-014 conv_tem  in  16  converted integer-Celsius result from the datapath.
REQ-015 tem_out  out  16  latched converted temperature.
REQ-016 hum_raw  out  16  latched raw humidity.
REQ-017 data_valid  out  1  one-cycle pulse when tem_out/hum_raw update.
REQ-018 err_cnt  out  8  count of failed measurements; saturates at 255.

Function
REQ-019 States: IDLE, TRIG, WAIT_MEAS, READ, CHECK, CONV, PUBLISH, ERR.
REQ-020 Period counter runs while enable=1 and wraps from PERIOD_CYC-1 to 0; the wrap sets a start flag that is cleared on IDLE->TRIG.
REQ-021 IDLE->TRIG when the start flag is set and enable=1; a start flag set outside IDLE is held, never dropped or double-counted.
REQ-022 TRIG: i2c_req=1, i2c_cmd=0; on i2c_done with i2c_err=0 go to WAIT_MEAS; with i2c_err=1 go to ERR.
REQ-023 WAIT_MEAS: count MEAS_WAIT_CYC clocks, then go to READ.
REQ-024 READ: i2c_req=1, i2c_cmd=1; on i2c_done capture i2c_rdata and go to CHECK; with i2c_err=1 go to ERR.
REQ-025 CHECK (1 cycle): CRC pass -> CONV; fail -> ERR.
REQ-026 CONV: drive raw_tem=T and hold it stable for CONV_LAT+1 clocks, then sample conv_tem into tem_out and go to PUBLISH.
REQ-027 PUBLISH: latch hum_raw=H, pulse data_valid for 1 cycle, go to IDLE.
REQ-028 ERR: increment the retry counter; if retries < RETRY_MAX go to TRIG; otherwise increment err_cnt (saturating), clear retries, go to IDLE with tem_out/hum_raw unchanged.
REQ-029 Retry counter clears on PUBLISH.
REQ-030 enable deasserted mid-measurement: finish the current measurement, then stay in IDLE; the period counter holds its value.
REQ-031 i2c_done outside TRIG/READ is ignored.

Reset
REQ-032 Reset puts the FSM in IDLE; all counters are 0; i2c_req=0; i2c_cmd=0; raw_tem, tem_out, hum_raw are 0x0000; data_valid=0; err_cnt=0.
REQ-033 Reset mid-transaction drops i2c_req in the same cycle and takes effect asynchronously.

Configuration
REQ-034 Macro SHT_CRC_CHECK_EN defined: CHECK verifies CRC_T over T and CRC_H over H with CRC-8, poly 0x31, init 0xFF, no reflection, no final XOR.
REQ-035 Macro undefined: CHECK always passes and the CRC bytes are ignored.

Structure
REQ-036 Shared package sht_pkg holds the state enum, command codes, CRC polynomial and init constants.
REQ-037 Sub-module crc8_sht computes the combinational 16-bit-in, 8-bit-out CRC and is instantiated twice only under SHT_CRC_CHECK_EN.

Verification
REQ-038 Nominal: T=0x8000, H=0x4000, valid CRCs, behavioural datapath -> raw_tem=0x8000 for 4 clocks; tem_out=0x002A, hum_raw=0x4000, one data_valid pulse.
REQ-039 CRC: T=0xBEEF with CRC_T=0x92 -> pass; CRC_T=0x93 -> retry; 4 consecutive bad reads -> err_cnt=1, no data_valid.
REQ-040 NACK: i2c_err=1 on the first TRIG only -> one retry, then normal publish; err_cnt stays 0.
REQ-041 Period: PERIOD_CYC=100, MEAS_WAIT_CYC=5 -> i2c_req rises every 100 clocks; enable=0 mid-WAIT_MEAS -> that measurement publishes and no further i2c_req follows.
REQ-042 Reset asserted during READ -> i2c_req=0 immediately; all outputs are at reset values; a new measurement starts after the first period wrap.

Source files
------------

// File: rtl/sht_pkg.sv
// rtl/sht_pkg.sv - shared state codes, I2C command codes and CRC constants for the SHT scheduler
package sht_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TRIG    = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_READ    = 3'd3;
    localparam state_t ST_CHECK   = 3'd4;
    localparam state_t ST_CONV    = 3'd5;
    localparam state_t ST_PUBLISH = 3'd6;
    localparam state_t ST_ERR     = 3'd7;

    localparam logic CMD_TRIG = 1'b0;
    localparam logic CMD_READ = 1'b1;

    localparam logic [7:0] CRC_POLY = 8'h31;
    localparam logic [7:0] CRC_INIT = 8'hFF;

endpackage

// File: rtl/crc8_sht.sv
// rtl/crc8_sht.sv - combinational CRC-8 (poly 0x31, init 0xFF, MSB first) over one 16-bit sensor word
module crc8_sht
    import sht_pkg::*;
(
    input  logic [15:0] data,
    output logic [7:0]  crc
);

    logic [7:0] c;

    always_comb begin
        c = CRC_INIT;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ data[i]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc = c;
    end

endmodule

// File: rtl/sht_meas_sched.sv
// rtl/sht_meas_sched.sv - periodic SHT trigger/read/convert/publish scheduler with bounded retries
// Define SHT_CRC_CHECK_EN to verify the sensor CRC bytes; otherwise every read is accepted.
module sht_meas_sched
    import sht_pkg::*;
#(
    parameter int unsigned PERIOD_CYC    = 12_000_000,
    parameter int unsigned MEAS_WAIT_CYC = 180_000,
    parameter int unsigned CONV_LAT      = 3,
    parameter int unsigned RETRY_MAX     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        i2c_req,
    output logic        i2c_cmd,
    input  logic        i2c_done,
    input  logic        i2c_err,
    input  logic [47:0] i2c_rdata,
    output logic [15:0] raw_tem,
    input  logic [15:0] conv_tem,
    output logic [15:0] tem_out,
    output logic [15:0] hum_raw,
    output logic        data_valid,
    output logic [7:0]  err_cnt
);

    localparam int PER_W  = $clog2(PERIOD_CYC + 1);
    localparam int WAIT_W = $clog2(MEAS_WAIT_CYC + 1);
    localparam int CONV_W = $clog2(CONV_LAT + 2);
    localparam int RTRY_W = $clog2(RETRY_MAX + 2);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEAS_WAIT_CYC - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_LAT);
    localparam logic [RTRY_W-1:0] RTRY_LIM  = RTRY_W'(RETRY_MAX);

    state_t             state;
    logic [PER_W-1:0]   per_cnt;
    logic               start_flag;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CONV_W-1:0]  conv_cnt;
    logic [RTRY_W-1:0]  retry_cnt;
    logic [15:0]        t_q;
    logic [15:0]        h_q;
    logic               crc_ok;
    logic               per_wrap;
    logic               go;
    logic               read_ok;

    assign per_wrap   = enable && (per_cnt == PER_LAST);
    assign go         = (state == ST_IDLE) && start_flag && enable;
    assign read_ok    = (state == ST_READ) && i2c_done && !i2c_err;
    assign i2c_req    = (state == ST_TRIG) || (state == ST_READ);
    assign i2c_cmd    = (state == ST_READ) ? CMD_READ : CMD_TRIG;
    assign data_valid = (state == ST_PUBLISH);

    // A wrap during a running measurement stays pending until the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt    <= '0;
            start_flag <= 1'b0;
        end else begin
            if (enable) begin
                per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
            end
            start_flag <= per_wrap | (start_flag & ~go);
        end
    end

`ifdef SHT_CRC_CHECK_EN
    logic [7:0] crc_t_q;
    logic [7:0] crc_h_q;
    logic [7:0] crc_t_calc;
    logic [7:0] crc_h_calc;

    crc8_sht u_crc_t (.data(t_q), .crc(crc_t_calc));
    crc8_sht u_crc_h (.data(h_q), .crc(crc_h_calc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_t_q <= 8'h00;
            crc_h_q <= 8'h00;
        end else if (read_ok) begin
            crc_t_q <= i2c_rdata[31:24];
            crc_h_q <= i2c_rdata[7:0];
        end
    end

    assign crc_ok = (crc_t_calc == crc_t_q) && (crc_h_calc == crc_h_q);
`else
    logic unused_crc_bytes;

    assign unused_crc_bytes = ^{i2c_rdata[31:24], i2c_rdata[7:0]};
    assign crc_ok           = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            conv_cnt  <= '0;
            retry_cnt <= '0;
            t_q       <= 16'h0000;
            h_q       <= 16'h0000;
            raw_tem   <= 16'h0000;
            tem_out   <= 16'h0000;
            hum_raw   <= 16'h0000;
            err_cnt   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (i2c_done) begin
                        state <= i2c_err ? ST_ERR : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= ST_READ;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    if (i2c_done) begin
                        if (i2c_err) begin
                            state <= ST_ERR;
                        end else begin
                            t_q   <= i2c_rdata[47:32];
                            h_q   <= i2c_rdata[23:8];
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (crc_ok) begin
                        raw_tem  <= t_q;
                        conv_cnt <= '0;
                        state    <= ST_CONV;
                    end else begin
                        state <= ST_ERR;
                    end
                end
                // raw_tem is held for CONV_LAT+1 clocks so the last cycle sees the fully settled result.
                ST_CONV: begin
                    if (conv_cnt == CONV_LAST) begin
                        tem_out <= conv_tem;
                        hum_raw <= h_q;
                        raw_tem <= 16'h0000;
                        state   <= ST_PUBLISH;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    retry_cnt <= '0;
                    state     <= ST_IDLE;
                end
                ST_ERR: begin
                    if (retry_cnt < RTRY_LIM) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= ST_TRIG;
                    end else begin
                        retry_cnt <= '0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
